// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
//   Shared defaults and types for the convolution frame sequencer.
//   CONV_N          : image width/height in pixels
//   CONV_K          : kernel size
//   CONV_PIPE_LAT   : cycles from window shift to MAC result
//   CONV_ADDR_WIDTH : ROM address width for the default image size
//   state_e         : sequencer FSM states
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int CONV_N          = 100;
  localparam int CONV_K          = 3;
  localparam int CONV_PIPE_LAT   = 4;
  localparam int CONV_ADDR_WIDTH = $clog2(CONV_N * CONV_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/conv_scheduler_if.sv
// -----------------------------------------------------------------------------
// conv_scheduler_if
//   Control/ROM/status bundle between the frame sequencer and its user.
//   start_i, stall_i : requests into the sequencer
//   rd_en_o, rd_addr_o : image ROM read port
//   shift_en_o, win_valid_o : line-buffer window control
//   valid_o, running_o, done_o : MAC-aligned sample flag and frame status
//   Modport slave is the sequencer side; master is the controlling side.
// -----------------------------------------------------------------------------
interface conv_scheduler_if
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH
);

  logic                  start_i;
  logic                  stall_i;
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  shift_en_o;
  logic                  win_valid_o;
  logic                  valid_o;
  logic                  running_o;
  logic                  done_o;

  modport slave (
    input  start_i, stall_i,
    output rd_en_o, rd_addr_o, shift_en_o, win_valid_o, valid_o, running_o, done_o
  );

  modport master (
    output start_i, stall_i,
    input  rd_en_o, rd_addr_o, shift_en_o, win_valid_o, valid_o, running_o, done_o
  );

endinterface

// File: rtl/conv_delay_line.sv
// -----------------------------------------------------------------------------
// conv_delay_line
//   Stallable 1-bit shift register of DEPTH stages.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears every stage
//   stall_i : holds every stage and forces q_o low
//   d_i     : serial input
//   q_o     : d_i delayed DEPTH unstalled cycles, 0 while stalled
// -----------------------------------------------------------------------------
module conv_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign sr_d[gi] = d_i;
      end else begin : g_tail
        assign sr_d[gi] = sr_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (!stall_i) begin
      sr_q <= sr_d;
    end
  end

  // The tail is masked during a stall so a frozen pipeline never reports
  // the same sample twice.
  assign q_o = sr_q[DEPTH-1] & ~stall_i;

endmodule

// File: rtl/conv_scheduler.sv
// -----------------------------------------------------------------------------
// conv_scheduler
//   Frame sequencer for the convolution datapath. Raster-scans an N x N image
//   out of a 1-cycle-latency ROM, strobes the line-buffer shift, flags windows
//   lying fully inside the image, and aligns that flag with the MAC output.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any frame, no done_o)
//   bus : conv_scheduler_if.slave
//         start_i   frame request, sampled only in IDLE
//         stall_i   freezes state, counters and delay stages
//         rd_en_o / rd_addr_o      ROM read, address row*N+col
//         shift_en_o / win_valid_o line-buffer shift and full-window flag
//         valid_o                  MAC result is a valid sample
//         running_o / done_o       frame in progress / end-of-frame pulse
// -----------------------------------------------------------------------------
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int N          = CONV_N,
  parameter int K          = CONV_K,
  parameter int PIPE_LAT   = CONV_PIPE_LAT,
  parameter int ADDR_WIDTH = $clog2(N * N)
) (
  input  logic           clk,
  input  logic           rst,
  conv_scheduler_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N * N - 1);
  localparam logic [CW-1:0]         LAST_COL   = CW'(N - 1);
  localparam logic [CW-1:0]         WIN_FIRST  = CW'(K - 1);
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(PIPE_LAT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [DW-1:0]         drain_q, drain_d;

  logic rd_en;
  logic running;
  logic done;
  logic win_in;
  logic shift_en;
  logic win_valid;
  logic valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A stall holds the current state, including in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!bus.stall_i) begin
      unique case (state_q)
        IDLE:    if (bus.start_i) state_d = RUN;
        RUN:     if (addr_q == LAST_ADDR) state_d = DRAIN;
        DRAIN:   if (drain_q == DRAIN_LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_en   = (state_q == RUN);
    running = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    // Only pixels that complete a K x K window inside the image qualify;
    // the col test also rejects windows that would straddle two rows.
    win_in  = rd_en && (row_q >= WIN_FIRST) && (col_q >= WIN_FIRST);
  end

  // ---------------------------------------------------------------------------
  // Raster counters. The address is incremented alongside col/row so no
  // multiplier is needed; all counters return to 0 after the last read so
  // the next frame starts clean.
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    if (!bus.stall_i) begin
      if (state_q == RUN) begin
        if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          col_d  = '0;
          row_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      // Counts unstalled DRAIN cycles; PIPE_LAT+1 of them flush the pipeline.
      drain_d = ((state_q == DRAIN) && (drain_q != DRAIN_LAST)) ? drain_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay stages. ROM data arrives one cycle after the read, so the shift
  // strobe and window flag both trail the read by one unstalled cycle; the
  // MAC flag trails the window flag by PIPE_LAT more.
  // ---------------------------------------------------------------------------
  conv_delay_line #(.DEPTH(1)) u_shift_dly (
    .clk     (clk),
    .rst     (rst),
    .stall_i (bus.stall_i),
    .d_i     (rd_en),
    .q_o     (shift_en)
  );

  conv_delay_line #(.DEPTH(1)) u_win_dly (
    .clk     (clk),
    .rst     (rst),
    .stall_i (bus.stall_i),
    .d_i     (win_in),
    .q_o     (win_valid)
  );

  // Fed from the masked window flag: while stalled this line does not
  // advance, so the masked value is never captured.
  conv_delay_line #(.DEPTH(PIPE_LAT)) u_valid_dly (
    .clk     (clk),
    .rst     (rst),
    .stall_i (bus.stall_i),
    .d_i     (win_valid),
    .q_o     (valid)
  );

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = addr_q;
  assign bus.shift_en_o  = shift_en;
  assign bus.win_valid_o = win_valid;
  assign bus.valid_o     = valid;
  assign bus.running_o   = running;
  assign bus.done_o      = done;

endmodule

// File: tb/tb_conv_scheduler.sv
module tb_conv_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_scheduler_if #(.ADDR_WIDTH(14)) bus_a ();
  conv_scheduler_if #(.ADDR_WIDTH(5))  bus_b ();

  // Default-size instance
  conv_scheduler #(.N(100), .K(3), .PIPE_LAT(4), .ADDR_WIDTH(14)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  // Small instance for exhaustive window-position checking
  conv_scheduler #(.N(5), .K(3), .PIPE_LAT(1), .ADDR_WIDTH(5)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit win_ok(input int pix, input int n, input int k);
    return (pix >= 0) && ((pix / n) >= k - 1) && ((pix % n) >= k - 1);
  endfunction

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor for instance A (sampled mid-cycle)
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int ucyc_a = 0;
  int hist_a [64] = '{default: -1};
  int reads_a, valids_a, dones_a, addr_err_a, win_err_a, align_err_a, stall_err_a, run_at_done_a;
  int start_cyc_a, first_read_a, first_valid_a, last_valid_a, done_cyc_a, last_run_a, exp_addr_a;
  bit done_seen_a;

  task automatic clear_a();
    reads_a = 0; valids_a = 0; dones_a = 0; addr_err_a = 0; win_err_a = 0;
    align_err_a = 0; stall_err_a = 0; run_at_done_a = 0;
    start_cyc_a = -1; first_read_a = -1; first_valid_a = -1; last_valid_a = -1;
    done_cyc_a = -1; last_run_a = -1; exp_addr_a = 0; done_seen_a = 1'b0;
  endtask

  always @(negedge clk) begin
    int pix;
    cyc++;
    if (!rst) begin
      if (bus_a.start_i && !bus_a.stall_i && !bus_a.running_o && !bus_a.done_o)
        start_cyc_a = cyc;
      if (bus_a.stall_i) begin
        if (bus_a.shift_en_o || bus_a.win_valid_o || bus_a.valid_o) stall_err_a++;
      end else begin
        pix = hist_a[(ucyc_a - 1) & 63];
        if (bus_a.shift_en_o != (pix >= 0)) align_err_a++;
        if (bus_a.win_valid_o && !win_ok(pix, 100, 3)) win_err_a++;
        if (bus_a.valid_o) begin
          pix = hist_a[(ucyc_a - 5) & 63];
          if (!win_ok(pix, 100, 3)) win_err_a++;
          valids_a++;
          if (first_valid_a < 0) first_valid_a = cyc;
          last_valid_a = cyc;
        end
        if (bus_a.rd_en_o) begin
          reads_a++;
          if (int'(bus_a.rd_addr_o) != exp_addr_a) addr_err_a++;
          exp_addr_a++;
          if (first_read_a < 0) first_read_a = cyc;
          hist_a[ucyc_a & 63] = int'(bus_a.rd_addr_o);
        end else begin
          hist_a[ucyc_a & 63] = -1;
        end
        ucyc_a++;
      end
      if (bus_a.running_o) last_run_a = cyc;
      if (bus_a.done_o) begin
        dones_a++;
        done_cyc_a = cyc;
        done_seen_a = 1'b1;
        if (bus_a.running_o) run_at_done_a++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor for instance B (never stalled)
  // ---------------------------------------------------------------------------
  int ucyc_b = 0;
  int hist_b [8] = '{default: -1};
  int reads_b = 0, valids_b = 0, dones_b = 0, addr_err_b = 0;
  logic [24:0] mask_b = '0;

  always @(negedge clk) begin
    int pix;
    if (!rst) begin
      if (bus_b.valid_o) begin
        pix = hist_b[(ucyc_b - 2) & 7];
        valids_b++;
        if (pix >= 0) mask_b[pix] = 1'b1;
      end
      if (bus_b.rd_en_o) begin
        if (int'(bus_b.rd_addr_o) != reads_b) addr_err_b++;
        reads_b++;
        hist_b[ucyc_b & 7] = int'(bus_b.rd_addr_o);
      end else begin
        hist_b[ucyc_b & 7] = -1;
      end
      ucyc_b++;
      if (bus_b.done_o) dones_b++;
    end
  end

  task automatic pulse_start_a();
    bus_a.start_i = 1'b1;
    wait_cycle();
    bus_a.start_i = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    for (int i = 0; i < budget && !done_seen_a; i++) wait_cycle();
    check(tag, done_seen_a, 1);
  endtask

  task automatic wait_addr_a(input int addr, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_a.rd_en_o && int'(bus_a.rd_addr_o) == addr) begin
        found = 1'b1;
        break;
      end
      wait_cycle();
    end
    check($sformatf("reach_addr_%0d", addr), found, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    bus_a.start_i = 1'b0;
    bus_a.stall_i = 1'b0;
    bus_b.start_i = 1'b0;
    bus_b.stall_i = 1'b0;
    clear_a();

    #24;
    check("reset_outputs_a", {bus_a.rd_en_o, bus_a.rd_addr_o, bus_a.shift_en_o, bus_a.win_valid_o,
                              bus_a.valid_o, bus_a.running_o, bus_a.done_o}, 0);
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    check("idle_outputs_b", {bus_b.rd_en_o, bus_b.rd_addr_o, bus_b.valid_o, bus_b.running_o, bus_b.done_o}, 0);

    // Small image: only windows with r,c in 2..4 produce samples
    bus_b.start_i = 1'b1;
    wait_cycle();
    bus_b.start_i = 1'b0;
    for (int i = 0; i < 100 && dones_b == 0; i++) wait_cycle();
    check("n5_reads", reads_b, 25);
    check("n5_addr_order", addr_err_b, 0);
    check("n5_valids", valids_b, 9);
    // bits 12-14, 17-19, 22-24
    check("n5_valid_mask", mask_b, 25'h1CE7000);
    check("n5_dones", dones_b, 1);

    // Frame 1: plain run
    clear_a();
    pulse_start_a();
    wait_done_a("f1_done_timeout", 11000);
    check("f1_reads", reads_a, 10000);
    check("f1_addr_order", addr_err_a, 0);
    check("f1_valids", valids_a, 9604);
    check("f1_window_pos", win_err_a, 0);
    check("f1_shift_align", align_err_a, 0);
    check("f1_first_read_ofs", first_read_a - start_cyc_a, 1);
    // pixel (2,2) = addr 202, read at +203, shifted at +204, +4 pipe
    check("f1_first_valid_ofs", first_valid_a - start_cyc_a, 208);
    check("f1_last_valid_ofs", last_valid_a - start_cyc_a, 10005);
    check("f1_last_run_ofs", last_run_a - start_cyc_a, 10005);
    check("f1_done_ofs", done_cyc_a - start_cyc_a, 10006);
    check("f1_dones", dones_a, 1);
    check("f1_running_at_done", run_at_done_a, 0);

    // Frame 2: start right after done, stall at 150, ignored starts
    clear_a();
    pulse_start_a();
    wait_addr_a(150, 500);
    bus_a.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      check($sformatf("f2_stall_addr_%0d", i), bus_a.rd_addr_o, 150);
    end
    bus_a.stall_i = 1'b0;
    wait_addr_a(1000, 2000);
    pulse_start_a();
    for (int i = 0; i < 12000 && !(bus_a.running_o && !bus_a.rd_en_o); i++) wait_cycle();
    pulse_start_a();
    for (int i = 0; i < 20 && !bus_a.done_o; i++) wait_cycle();
    check("f2_in_done", bus_a.done_o, 1);
    pulse_start_a();
    repeat (20) wait_cycle();
    check("f2_reads", reads_a, 10000);
    check("f2_addr_order", addr_err_a, 0);
    check("f2_valids", valids_a, 9604);
    check("f2_window_pos", win_err_a, 0);
    check("f2_stall_quiet", stall_err_a, 0);
    check("f2_done_ofs", done_cyc_a - start_cyc_a, 10009);
    check("f2_dones", dones_a, 1);
    check("f2_idle_after", {bus_a.rd_en_o, bus_a.running_o}, 0);

    // Frame 3: reset mid-frame
    clear_a();
    pulse_start_a();
    wait_addr_a(5000, 6000);
    #2 rst = 1'b1;
    #1;
    check("f3_async_reset", {bus_a.rd_en_o, bus_a.rd_addr_o, bus_a.shift_en_o, bus_a.win_valid_o,
                             bus_a.valid_o, bus_a.running_o, bus_a.done_o}, 0);
    repeat (2) wait_cycle();
    rst = 1'b0;
    repeat (3) wait_cycle();
    check("f3_no_done", dones_a, 0);

    // Frame 4: full restart, stall on final read and on last DRAIN cycle
    clear_a();
    pulse_start_a();
    wait_addr_a(9999, 11000);
    bus_a.stall_i = 1'b1;
    wait_cycle();
    check("f4_final_hold", {bus_a.rd_en_o, bus_a.rd_addr_o}, {1'b1, 14'd9999});
    bus_a.stall_i = 1'b0;
    wait_cycle();
    check("f4_drain_no_read", bus_a.rd_en_o, 0);
    repeat (4) wait_cycle();
    bus_a.stall_i = 1'b1;
    wait_cycle();
    check("f4_drain_stall", {bus_a.running_o, bus_a.done_o}, 2'b10);
    bus_a.stall_i = 1'b0;
    wait_done_a("f4_done_timeout", 20);
    check("f4_reads", reads_a, 10000);
    check("f4_addr_order", addr_err_a, 0);
    check("f4_valids", valids_a, 9604);
    check("f4_window_pos", win_err_a, 0);
    check("f4_stall_quiet", stall_err_a, 0);
    check("f4_last_run_ofs", last_run_a - start_cyc_a, 10007);
    check("f4_done_ofs", done_cyc_a - start_cyc_a, 10008);
    check("f4_running_at_done", run_at_done_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
